wb_port_sched: RTL and testbench
================================

# wb_port_sched

Writeback-port scheduler for the register file. It shares the single RF write port between two requesters: the pipeline writeback stage, whose data source is chosen by wd_sel, and a long-latency unit (multi-cycle mul/div) that returns results through a valid/ready handshake. It issues at most one registered write per cycle, stalls the pipeline writeback stage when the long-latency unit is granted, and drives rf_we/rf_waddr/rf_wdata directly into the register file.

## Interface
- DW, 32, data width
- AW, 5, register address width
- STARVE_MAX, 4, cycles a waiting long-latency result may be refused before it is forced through; legal range 1..15
- cpu_clk  in  1  clock, rising edge
- cpu_rst_n  in  1  reset, asynchronous assert, active-low
- p_valid  in  1  pipeline WB stage holds a write
- p_rd  in  AW  pipeline destination register
- p_wd_sel  in  2  source select: 00 pc4, 01 ALU result, 10 data memory, 11 immediate
- p_pc4, p_aluc, p_dm, p_imm  in  DW each  candidate write values
- p_stall  out  1  hold WB stage this cycle (combinational)
- l_valid  in  1  long-latency result available
- l_rd  in  AW  long-latency destination register
- l_data  in  DW  long-latency result
- l_ready  out  1  long-latency result accepted this cycle (combinational)
- rf_we  out  1  RF write enable (registered)
- rf_waddr  out  AW  RF write address (registered)
- rf_wdata  out  DW  RF write data (registered)

## Operation
- Grant rules, evaluated each cycle:
  - force_l = l_valid && (starve_cnt == STARVE_MAX).
  - grant_l = l_valid && (!p_valid || force_l).
  - grant_p = p_valid && !grant_l.
- Outputs from the grant:
  - l_ready = grant_l.
  - p_stall = p_valid && grant_l.
- Write value selection:
  - For a pipeline grant, the write value is chosen by p_wd_sel: 00 p_pc4, 01 p_aluc, 10 p_dm, 11 p_imm.
  - For a long-latency grant, the write value is l_data.
- Starvation counter (the state):
  - Clears to 0 when l_valid is 0 or grant_l is 1.
  - Otherwise increments by 1, saturating at STARVE_MAX.
  - States are WAIT0..WAIT(STARVE_MAX); reaching WAIT(STARVE_MAX) forces the next grant to the long-latency unit.
- Handshake obligations on the requesters:
  - Once l_valid rises, l_valid, l_rd and l_data hold stable until l_ready.
  - While p_stall is high, all p_* inputs hold stable.
- x0 writes: a grant with rd == 0 still consumes the request (ready/no stall) but produces rf_we = 0.
- Simultaneous p_valid and l_valid with no force: the pipeline wins, l waits, and the counter increments.

## Timing
- Reset (cpu_rst_n low, any time):
  - rf_we, rf_waddr, rf_wdata and starve_cnt are 0.
  - p_stall and l_ready follow their combinational equations; they are 0 whenever both valids are 0.
  - A long-latency result pending at reset is dropped; the long-latency unit shares the same reset.
- Write latency: a grant in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1 (after the edge ending N), and the RF stores it at the end of N+1.
- rf_we is 1 for exactly one cycle per granted nonzero-rd request and is 0 in cycles following no grant.
- Maximum wait:
  - With WB_FAIRNESS_EN, a long-latency result is accepted within STARVE_MAX+1 cycles of l_valid rising.
  - The pipeline is stalled at most 1 cycle per long-latency result.

## Configuration
- WB_FAIRNESS_EN defined: the starvation counter and force_l are present, as described above.
- WB_FAIRNESS_EN undefined:
  - starve_cnt is removed and force_l is constant 0 (strict pipeline priority).
  - A long-latency result waits until a cycle with p_valid == 0.
  - STARVE_MAX is ignored.

## Structure
- The shared parameter header holds:
  - the wd_sel encodings (WD_PC4=00, WD_ALUC=01, WD_DM=10, WD_IMM=11);
  - the new grant-owner constants GNT_PIPE=0 and GNT_LL=1, used to register the last grant owner for debug.
- One combinational sub-module, wb_src_sel, performs the 4:1 pipeline value select. The scheduler instantiates it once and muxes its output with l_data by grant.

## Test plan
- Reset mid-write:
  - Stimulus: p_valid=1, p_rd=5, p_wd_sel=01, p_aluc=0x1234; pull cpu_rst_n low in the same cycle.
  - Response: rf_we=0, rf_waddr=0, rf_wdata=0 immediately; nothing written after release until the next grant.
- Source select:
  - Stimulus: four consecutive pipeline writes to rd=1..4 with wd_sel 00/01/10/11 and pc4=0x10, aluc=0x20, dm=0x30, imm=0x40.
  - Response: rf writes (1,0x10), (2,0x20), (3,0x30), (4,0x40), each one cycle after its request, with p_stall=0 throughout.
- Idle-slot long-latency grant:
  - Stimulus: l_valid=1, l_rd=7, l_data=0xCAFE, p_valid=0.
  - Response: l_ready=1 in the same cycle; rf_we=1, waddr=7, wdata=0xCAFE next cycle.
- Forced grant (WB_FAIRNESS_EN defined, STARVE_MAX=4):
  - Stimulus: p_valid held 1 continuously and l_valid=1 from cycle 0.
  - Response: l_ready=0 in cycles 0–3; cycle 4 has l_ready=1 and p_stall=1; cycle 5 writes l_rd; the pipeline write resumes in cycle 5 with its write appearing in cycle 6.
- Strict priority (WB_FAIRNESS_EN undefined):
  - Stimulus: the same stimulus as the forced-grant case, held 20 cycles.
  - Response: l_ready=0 for all 20 cycles and p_stall never asserts.
  - Then drop p_valid: l_ready=1 in that cycle.
- x0 write:
  - Stimulus: a pipeline request with p_rd=0, simultaneous with l_valid carrying l_rd=0.
  - Response: both requests are consumed over two cycles (pipeline first), and rf_we stays 0 throughout.

Source files
------------

// File: rtl/wb_port_sched_pkg.sv
// Shared constants and types for the writeback-port scheduler.
package wb_port_sched_pkg;

  localparam int unsigned WB_DW         = 32;
  localparam int unsigned WB_AW         = 5;
  localparam int unsigned WB_STARVE_MAX = 4;
  // Starvation counter width; holds any legal STARVE_MAX (1..15)
  localparam int unsigned WB_CNT_W      = 4;

  // Pipeline write-value source encodings
  typedef enum logic [1:0] {
    WD_PC4  = 2'b00,
    WD_ALUC = 2'b01,
    WD_DM   = 2'b10,
    WD_IMM  = 2'b11
  } wd_sel_e;

  // Owner of the most recent write-port grant (debug visibility)
  typedef enum logic {
    GNT_PIPE = 1'b0,
    GNT_LL   = 1'b1
  } gnt_owner_e;

endpackage

// File: rtl/wb_port_sched_if.sv
// Requester/RF-side bus of the writeback-port scheduler.
interface wb_port_sched_if
  import wb_port_sched_pkg::*;
#(
  parameter int unsigned DW = WB_DW,
  parameter int unsigned AW = WB_AW
);

  // Pipeline writeback stage
  logic          p_valid;
  logic [AW-1:0] p_rd;
  logic [1:0]    p_wd_sel;
  logic [DW-1:0] p_pc4;
  logic [DW-1:0] p_aluc;
  logic [DW-1:0] p_dm;
  logic [DW-1:0] p_imm;
  logic          p_stall;

  // Long-latency unit result
  logic          l_valid;
  logic [AW-1:0] l_rd;
  logic [DW-1:0] l_data;
  logic          l_ready;

  // Register-file write port
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  // Requesters and register file
  modport master (
    output p_valid, p_rd, p_wd_sel, p_pc4, p_aluc, p_dm, p_imm,
    output l_valid, l_rd, l_data,
    input  p_stall, l_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  // Scheduler
  modport slave (
    input  p_valid, p_rd, p_wd_sel, p_pc4, p_aluc, p_dm, p_imm,
    input  l_valid, l_rd, l_data,
    output p_stall, l_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_src_sel.sv
// 4:1 select of the pipeline writeback value by wd_sel.
module wb_src_sel
  import wb_port_sched_pkg::*;
#(
  parameter int unsigned DW = WB_DW
) (
  input  logic [1:0]    wd_sel_i,
  input  logic [DW-1:0] pc4_i,
  input  logic [DW-1:0] aluc_i,
  input  logic [DW-1:0] dm_i,
  input  logic [DW-1:0] imm_i,
  output logic [DW-1:0] wdata_c_o
);

  // Source mux
  always_comb begin
    wdata_c_o = pc4_i;
    case (wd_sel_i)
      WD_PC4:  wdata_c_o = pc4_i;
      WD_ALUC: wdata_c_o = aluc_i;
      WD_DM:   wdata_c_o = dm_i;
      WD_IMM:  wdata_c_o = imm_i;
      default: wdata_c_o = pc4_i;
    endcase
  end

endmodule

// File: rtl/wb_port_sched.sv
// Writeback-port scheduler: shares the single RF write port between the
// pipeline WB stage and a long-latency unit. Optional macro WB_FAIRNESS_EN
// adds a starvation counter that forces the long-latency result through
// after STARVE_MAX refusals; without it the pipeline has strict priority.
module wb_port_sched
  import wb_port_sched_pkg::*;
#(
  parameter int unsigned DW         = WB_DW,
  parameter int unsigned AW         = WB_AW,
  parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  wb_port_sched_if.slave        bus,
  output gnt_owner_e            dbg_gnt_owner_o
);

  if (STARVE_MAX == 0 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("wb_port_sched: STARVE_MAX must be in 1..15");
  end

  logic          force_l_c;
  logic          grant_l_c;
  logic          grant_p_c;
  logic [DW-1:0] p_wdata_c;

  logic          rf_we_q,    rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  gnt_owner_e    gnt_owner_q, gnt_owner_d;

  wb_src_sel #(.DW(DW)) u_src_sel (
    .wd_sel_i  (bus.p_wd_sel),
    .pc4_i     (bus.p_pc4),
    .aluc_i    (bus.p_aluc),
    .dm_i      (bus.p_dm),
    .imm_i     (bus.p_imm),
    .wdata_c_o (p_wdata_c)
  );

`ifdef WB_FAIRNESS_EN
  localparam logic [WB_CNT_W-1:0] CntMax = WB_CNT_W'(STARVE_MAX);

  logic [WB_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Starvation state register (WAIT0..WAIT(STARVE_MAX))
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) starve_cnt_q <= '0;
    else            starve_cnt_q <= starve_cnt_d;
  end

  // Next state: count refused cycles of a waiting result, saturating
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.l_valid || grant_l_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CntMax) begin
      starve_cnt_d = starve_cnt_q + WB_CNT_W'(1);
    end
  end

  assign force_l_c = bus.l_valid && (starve_cnt_q == CntMax);
`else
  assign force_l_c = 1'b0;
`endif

  // Grant decision and handshake outputs
  always_comb begin
    grant_l_c   = bus.l_valid && (!bus.p_valid || force_l_c);
    grant_p_c   = bus.p_valid && !grant_l_c;
    bus.l_ready = grant_l_c;
    bus.p_stall = bus.p_valid && grant_l_c;
  end

  // Next write: one registered write per grant; rd==0 consumes silently
  always_comb begin
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    gnt_owner_d = gnt_owner_q;
    if (grant_l_c) begin
      gnt_owner_d = GNT_LL;
      if (bus.l_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.l_rd;
        rf_wdata_d = bus.l_data;
      end
    end else if (grant_p_c) begin
      gnt_owner_d = GNT_PIPE;
      if (bus.p_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.p_rd;
        rf_wdata_d = p_wdata_c;
      end
    end
  end

  // Registered RF write port and last-grant owner
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      gnt_owner_q <= GNT_PIPE;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      gnt_owner_q <= gnt_owner_d;
    end
  end

  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign dbg_gnt_owner_o = gnt_owner_q;

endmodule

// File: tb/tb_wb_port_sched.sv
// Self-checking bench for wb_port_sched: directed cases plus random traffic
// checked against a cycle-level reference model of the grant rules.
module tb_wb_port_sched;
  import wb_port_sched_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned SM = 4;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst_n;
  gnt_owner_e dbg_owner;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       last_stall = 1'b0;
  logic       last_gl    = 1'b0;
  int         l_age      = 0;
  gnt_owner_e exp_owner  = GNT_PIPE;
`ifdef WB_FAIRNESS_EN
  int         l_refused  = 0;
`endif
  logic       lr_obs;
  int         first_acc;

  wb_port_sched_if #(.DW(DW), .AW(AW)) bus ();

  wb_port_sched #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
    .cpu_clk         (cpu_clk),
    .cpu_rst_n       (cpu_rst_n),
    .bus             (bus),
    .dbg_gnt_owner_o (dbg_owner)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s);
    case (s)
      2'b00:   return bus.p_pc4;
      2'b01:   return bus.p_aluc;
      2'b10:   return bus.p_dm;
      default: return bus.p_imm;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.p_valid  = 1'b0; bus.p_rd = '0; bus.p_wd_sel = 2'b00;
    bus.p_pc4    = '0; bus.p_aluc = '0; bus.p_dm = '0; bus.p_imm = '0;
    bus.l_valid  = 1'b0; bus.l_rd = '0; bus.l_data = '0;
  endtask

  task automatic model_reset();
    last_stall = 1'b0;
    last_gl    = 1'b0;
    l_age      = 0;
    exp_owner  = GNT_PIPE;
`ifdef WB_FAIRNESS_EN
    l_refused  = 0;
`endif
  endtask

  // One clock cycle with inputs already driven: check handshake, then write
  task automatic cycle(output logic obs_lr);
    logic        e_force, e_gl, e_gp, e_we;
    logic [31:0] e_addr, e_data;
    #1;
    e_force = 1'b0;
`ifdef WB_FAIRNESS_EN
    e_force = bus.l_valid && (l_refused >= int'(SM));
`endif
    e_gl = bus.l_valid && (!bus.p_valid || e_force);
    e_gp = bus.p_valid && !e_gl;
    if (bus.l_valid) l_age++;
    obs_lr = bus.l_ready;
    chk("l_ready", 32'(bus.l_ready), 32'(e_gl));
    chk("p_stall", 32'(bus.p_stall), 32'(bus.p_valid && e_gl));
`ifdef WB_FAIRNESS_EN
    if (e_gl) chk("max_wait_ok", 32'(l_age <= int'(SM) + 1), 32'd1);
`endif
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (e_gl) begin
      e_we = (bus.l_rd != 0); e_addr = 32'(bus.l_rd); e_data = bus.l_data;
      exp_owner = GNT_LL;
    end else if (e_gp) begin
      e_we = (bus.p_rd != 0); e_addr = 32'(bus.p_rd); e_data = pick(bus.p_wd_sel);
      exp_owner = GNT_PIPE;
    end
`ifdef WB_FAIRNESS_EN
    if (!bus.l_valid || e_gl) l_refused = 0;
    else if (l_refused < int'(SM)) l_refused++;
`endif
    if (!bus.l_valid || e_gl) l_age = 0;
    last_gl    = e_gl;
    last_stall = bus.p_valid && e_gl;
    @(posedge cpu_clk); #1;
    chk("rf_we", 32'(bus.rf_we), 32'(e_we));
    if (e_we) begin
      chk("rf_waddr", 32'(bus.rf_waddr), e_addr);
      chk("rf_wdata", bus.rf_wdata, e_data);
    end
    chk("gnt_owner", 32'(dbg_owner), 32'(exp_owner));
  endtask

  // Random requester traffic obeying the hold-until-accepted rules
  task automatic drive_random();
    if (!last_stall) begin
      bus.p_valid  = ($urandom_range(0, 99) < 60);
      bus.p_rd     = AW'($urandom_range(0, 31));
      bus.p_wd_sel = 2'($urandom_range(0, 3));
      bus.p_pc4    = $urandom; bus.p_aluc = $urandom;
      bus.p_dm     = $urandom; bus.p_imm  = $urandom;
    end
    if (!bus.l_valid || last_gl) begin
      bus.l_valid = ($urandom_range(0, 99) < 35);
      bus.l_rd    = AW'($urandom_range(0, 31));
      bus.l_data  = $urandom;
    end
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_l_ready", 32'(bus.l_ready), 32'd0);
    chk("rst_p_stall", 32'(bus.p_stall), 32'd0);
    cpu_rst_n = 1'b1;

    // Source select: rd 1..4 through each wd_sel
    bus.p_pc4 = 32'h10; bus.p_aluc = 32'h20; bus.p_dm = 32'h30; bus.p_imm = 32'h40;
    for (int i = 0; i < 4; i++) begin
      bus.p_valid  = 1'b1;
      bus.p_rd     = AW'(i + 1);
      bus.p_wd_sel = 2'(i);
      cycle(lr_obs);
      chk("srcsel_data", bus.rf_wdata, 32'h10 * 32'(i + 1));
    end

    // Idle-slot long-latency grant
    clear_inputs();
    bus.l_valid = 1'b1; bus.l_rd = AW'(7); bus.l_data = 32'hCAFE;
    cycle(lr_obs);
    chk("idle_lr", 32'(lr_obs), 32'd1);
    chk("idle_wdata", bus.rf_wdata, 32'hCAFE);

    // Pipeline held busy while a long-latency result waits
    clear_inputs();
    cycle(lr_obs);
    first_acc = -1;
    bus.l_valid = 1'b1; bus.l_rd = AW'(11); bus.l_data = 32'hBEEF0011;
    for (int c = 0; c < 20; c++) begin
      if (!last_stall) begin
        bus.p_valid  = 1'b1;
        bus.p_rd     = AW'((c % 30) + 1);
        bus.p_wd_sel = 2'b01;
        bus.p_aluc   = 32'h100 + 32'(c);
      end
      if (last_gl) bus.l_valid = 1'b0;
      cycle(lr_obs);
      if (lr_obs && first_acc < 0) first_acc = c;
    end
`ifdef WB_FAIRNESS_EN
    chk("force_cycle", 32'(first_acc), 32'(SM));
`else
    chk("strict_never", 32'(first_acc), 32'hFFFF_FFFF);
`endif
    bus.p_valid = 1'b0;
    cycle(lr_obs);

    // x0 writes from both requesters
    clear_inputs();
    cycle(lr_obs);
    bus.p_valid = 1'b1; bus.p_rd = '0; bus.p_aluc = 32'h55; bus.p_wd_sel = 2'b01;
    bus.l_valid = 1'b1; bus.l_rd = '0; bus.l_data = 32'h66;
    cycle(lr_obs);
    chk("x0_p_first", 32'(lr_obs), 32'd0);
    bus.p_valid = 1'b0;
    cycle(lr_obs);
    chk("x0_l_second", 32'(lr_obs), 32'd1);
    bus.l_valid = 1'b0;
    cycle(lr_obs);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive_random();
      cycle(lr_obs);
    end

    // Reset asserted mid-write after a real write
    clear_inputs();
    cycle(lr_obs);
    bus.p_valid = 1'b1; bus.p_rd = AW'(9); bus.p_wd_sel = 2'b11; bus.p_imm = 32'hABCD;
    cycle(lr_obs);
    bus.p_rd = AW'(5); bus.p_wd_sel = 2'b01; bus.p_aluc = 32'h1234;
    #1 cpu_rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(bus.rf_we), 32'd0);
    chk("midrst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("midrst_wdata", bus.rf_wdata, 32'd0);
    @(posedge cpu_clk); #1;
    chk("midrst_hold_we", 32'(bus.rf_we), 32'd0);
    chk("midrst_hold_waddr", 32'(bus.rf_waddr), 32'd0);
    clear_inputs();
    model_reset();
    cpu_rst_n = 1'b1;
    cycle(lr_obs);
    cycle(lr_obs);

    for (int n = 0; n < 100; n++) begin
      drive_random();
      cycle(lr_obs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
